// File: rtl/key_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module   : key_pulse_gen
// Brief    : Turns single-cycle internal events into fixed-width physical
//            pulses, each followed by a guaranteed idle gap. Events arriving
//            while a pulse or gap is in progress are queued in a saturating
//            counter and replayed back-to-back.
// Revision : 1.0 - initial release
// ============================================================================
module key_pulse_gen #(
  parameter int ON_CYCLES  = 7,    // active pulse width in clocks (>=1)
  parameter int OFF_CYCLES = 7,    // idle gap after each pulse in clocks (>=1)
  parameter int PEND_MAX   = 3,    // queue depth (>=1)
  parameter bit IDLE_LEVEL = 1'b1, // resting output level
  localparam int c_pend_w  = $clog2(PEND_MAX + 1)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_trig,
  input  logic                i_clear,
  output logic                o_out,
  output logic                o_busy,
  output logic [c_pend_w-1:0] o_pending,
  output logic                o_done,
  output logic                o_drop
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_cnt_max = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

  localparam logic [c_cnt_w-1:0]  c_on_load  = c_cnt_w'(ON_CYCLES - 1);
  localparam logic [c_cnt_w-1:0]  c_off_load = c_cnt_w'(OFF_CYCLES - 1);
  localparam logic [c_cnt_w-1:0]  c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_pend_w-1:0] c_pend_max = c_pend_w'(PEND_MAX);
  localparam logic [c_pend_w-1:0] c_pend_one = c_pend_w'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  state_t                state_q, state_d;
  logic [c_cnt_w-1:0]    cnt_q,   cnt_d;
  logic [c_pend_w-1:0]   pend_q,  pend_d;
  logic                  out_q,   out_d;
  logic                  busy_q,  busy_d;
  logic                  done_q,  done_d;
  logic                  drop_q,  drop_d;

  logic                  w_cnt_zero;
  logic                  w_active;
  logic                  w_consume_slot;

  // The last GAP cycle is the only point where a queued event can be consumed.
  assign w_cnt_zero     = (cnt_q == '0);
  assign w_active       = (state_q == S_ON) || (state_q == S_GAP);
  assign w_consume_slot = (state_q == S_GAP) && w_cnt_zero;

  // Next-state, counter, queue and output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    done_d  = 1'b0;
    drop_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Queue is always empty here; a clear alongside a trig wins.
        pend_d = '0;
        if (i_trig && !i_clear) begin
          state_d = S_ON;
          cnt_d   = c_on_load;
        end
      end

      S_ON: begin
        if (w_cnt_zero) begin
          state_d = S_GAP;
          cnt_d   = c_off_load;
        end else begin
          cnt_d = cnt_q - c_cnt_one;
        end
      end

      S_GAP: begin
        if (!w_cnt_zero) begin
          cnt_d = cnt_q - c_cnt_one;
        end else if (!i_clear && ((pend_q != '0) || i_trig)) begin
          // Go straight into the next pulse: no extra idle cycle in between.
          state_d = S_ON;
          cnt_d   = c_on_load;
        end else begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        pend_d  = '0;
      end
    endcase

    // Event queue while a pulse or gap is in progress.
    if (w_active) begin
      if (i_clear) begin
        // Flush; the same-cycle trig is discarded silently.
        pend_d = '0;
      end else if (w_consume_slot) begin
        // A trig here cancels against the consume, so the count either holds
        // (trig present) or drops by one (no trig). Never a drop at this point.
        if (!i_trig && (pend_q != '0)) begin
          pend_d = pend_q - c_pend_one;
        end
      end else if (i_trig) begin
        if (pend_q == c_pend_max) begin
          drop_d = 1'b1;
        end else begin
          pend_d = pend_q + c_pend_one;
        end
      end
    end

    out_d  = (state_d == S_ON) ? ~IDLE_LEVEL : IDLE_LEVEL;
    busy_d = (state_d != S_IDLE);
  end

  // State register with asynchronous reset; reset aborts any pulse in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      out_q   <= IDLE_LEVEL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  assign o_out     = out_q;
  assign o_busy    = busy_q;
  assign o_pending = pend_q;
  assign o_done    = done_q;
  assign o_drop    = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_key_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_pulse_gen
// Brief    : Self-checking bench for key_pulse_gen. Two instances share the
//            stimulus: A uses the defaults, B is active-high with 1/1 timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_pulse_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trig = 1'b0;
  logic       clear = 1'b0;

  logic       out_a, busy_a, done_a, drop_a;
  logic [1:0] pend_a;
  logic       out_b, busy_b, done_b, drop_b;
  logic [1:0] pend_b;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    int scn;
    int cyc;
    int out;
    int busy;
    int pend;
    int done;
    int drop;
  } vec_t;

  vec_t vecs[$];

  key_pulse_gen u_dut_a (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_trig   (trig),
    .i_clear  (clear),
    .o_out    (out_a),
    .o_busy   (busy_a),
    .o_pending(pend_a),
    .o_done   (done_a),
    .o_drop   (drop_a)
  );

  key_pulse_gen #(
    .ON_CYCLES (1),
    .OFF_CYCLES(1),
    .PEND_MAX  (3),
    .IDLE_LEVEL(1'b0)
  ) u_dut_b (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_trig   (trig),
    .i_clear  (clear),
    .o_out    (out_b),
    .o_busy   (busy_b),
    .o_pending(pend_b),
    .o_done   (done_b),
    .o_drop   (drop_b)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Hard stop in case something stalls
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within budget");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input int s, input int c, input int o, input int b,
                     input int p, input int d, input int dr);
    vec_t v;
    v.scn = s; v.cyc = c; v.out = o; v.busy = b; v.pend = p; v.done = d; v.drop = dr;
    vecs.push_back(v);
  endtask

  task automatic check_vec(input int dut, input vec_t v);
    int o, b, p, d, dr;
    if (dut == 0) begin
      o = int'(out_a); b = int'(busy_a); p = int'(pend_a); d = int'(done_a); dr = int'(drop_a);
    end else begin
      o = int'(out_b); b = int'(busy_b); p = int'(pend_b); d = int'(done_b); dr = int'(drop_b);
    end
    chk($sformatf("s%0d c%0d out", v.scn, v.cyc), o, v.out);
    chk($sformatf("s%0d c%0d busy", v.scn, v.cyc), b, v.busy);
    chk($sformatf("s%0d c%0d pending", v.scn, v.cyc), p, v.pend);
    chk($sformatf("s%0d c%0d done", v.scn, v.cyc), d, v.done);
    chk($sformatf("s%0d c%0d drop", v.scn, v.cyc), dr, v.drop);
  endtask

  // Reset, then run n cycles. Cycle 0 is the first cycle after reset release;
  // inputs for cycle c are sampled by the posedge ending cycle c.
  task automatic run_scn(input int s, input int dut, input logic [63:0] tm,
                         input logic [63:0] cm, input int n, input int exp_pulses);
    int   pulses;
    logic prev_act;
    logic act;
    trig  = 1'b0;
    clear = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pulses   = 0;
    prev_act = 1'b0;
    for (int c = 0; c < n; c++) begin
      if (c > 0) @(negedge clk);
      act = (dut == 0) ? (out_a == 1'b0) : (out_b == 1'b1);
      if (act && !prev_act) pulses++;
      prev_act = act;
      for (int k = 0; k < vecs.size(); k++) begin
        if (vecs[k].scn == s && vecs[k].cyc == c) check_vec(dut, vecs[k]);
      end
      trig  = tm[c];
      clear = cm[c];
    end
    trig  = 1'b0;
    clear = 1'b0;
    chk($sformatf("s%0d pulses", s), pulses, exp_pulses);
  endtask

  initial begin
    logic [63:0] tm;
    logic [63:0] cm;
    int          act_cycles;
    int          starts;
    logic        prev;

    // ---- expected-value table: scn, cycle, out, busy, pending, done, drop ----
    // S0: single trig at cycle 0
    add(0, 0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 0);
    add(0, 7, 0, 1, 0, 0, 0);
    add(0, 8, 1, 1, 0, 0, 0);
    add(0, 14, 1, 1, 0, 0, 0);
    add(0, 15, 1, 0, 0, 1, 0);
    add(0, 16, 1, 0, 0, 0, 0);
    // S1: trig at 0, 3, 5
    add(1, 4, 0, 1, 1, 0, 0);
    add(1, 6, 0, 1, 2, 0, 0);
    add(1, 14, 1, 1, 2, 0, 0);
    add(1, 15, 0, 1, 1, 0, 0);
    add(1, 21, 0, 1, 1, 0, 0);
    add(1, 22, 1, 1, 1, 0, 0);
    add(1, 29, 0, 1, 0, 0, 0);
    add(1, 35, 0, 1, 0, 0, 0);
    add(1, 42, 1, 1, 0, 0, 0);
    add(1, 43, 1, 0, 0, 1, 0);
    // S2: trig held 0..5, saturation and drops
    add(2, 2, 0, 1, 1, 0, 0);
    add(2, 4, 0, 1, 3, 0, 0);
    add(2, 5, 0, 1, 3, 0, 1);
    add(2, 6, 0, 1, 3, 0, 1);
    add(2, 7, 0, 1, 3, 0, 0);
    add(2, 15, 0, 1, 2, 0, 0);
    add(2, 29, 0, 1, 1, 0, 0);
    add(2, 43, 0, 1, 0, 0, 0);
    add(2, 56, 1, 1, 0, 0, 0);
    add(2, 57, 1, 0, 0, 1, 0);
    // S3: trig at 0 and on the last GAP cycle
    add(3, 14, 1, 1, 0, 0, 0);
    add(3, 15, 0, 1, 0, 0, 0);
    add(3, 21, 0, 1, 0, 0, 0);
    add(3, 22, 1, 1, 0, 0, 0);
    add(3, 29, 1, 0, 0, 1, 0);
    // S4: three queued, clear at 10
    add(4, 4, 0, 1, 3, 0, 0);
    add(4, 10, 1, 1, 3, 0, 0);
    add(4, 11, 1, 1, 0, 0, 0);
    add(4, 14, 1, 1, 0, 0, 0);
    add(4, 15, 1, 0, 0, 1, 0);
    add(4, 20, 1, 0, 0, 0, 0);
    // S5: trig+clear together mid-pulse
    add(5, 5, 0, 1, 0, 0, 0);
    add(5, 15, 1, 0, 0, 1, 0);
    // S6: trig+clear in IDLE, then clear alone
    add(6, 1, 1, 0, 0, 0, 0);
    add(6, 2, 1, 0, 0, 0, 0);
    add(6, 3, 1, 0, 0, 0, 0);
    // S7: trig+consume at PEND_MAX never drops
    add(7, 14, 1, 1, 3, 0, 0);
    add(7, 15, 0, 1, 3, 0, 0);
    add(7, 16, 0, 1, 3, 0, 0);
    // S8: clear on the last GAP cycle with an event queued
    add(8, 14, 1, 1, 1, 0, 0);
    add(8, 15, 1, 0, 0, 1, 0);
    // S9: instance B, active-high, ON=1 OFF=1
    add(9, 0, 0, 0, 0, 0, 0);
    add(9, 1, 1, 1, 0, 0, 0);
    add(9, 2, 0, 1, 1, 0, 0);
    add(9, 3, 1, 1, 0, 0, 0);
    add(9, 4, 0, 1, 0, 0, 0);
    add(9, 5, 0, 0, 0, 1, 0);

    // ---- apply the table ----
    tm = '0; cm = '0; tm[0] = 1'b1;
    run_scn(0, 0, tm, cm, 20, 1);

    tm = '0; cm = '0; tm[0] = 1'b1; tm[3] = 1'b1; tm[5] = 1'b1;
    run_scn(1, 0, tm, cm, 46, 3);

    tm = '0; cm = '0;
    for (int i = 0; i <= 5; i++) tm[i] = 1'b1;
    run_scn(2, 0, tm, cm, 60, 4);

    tm = '0; cm = '0; tm[0] = 1'b1; tm[14] = 1'b1;
    run_scn(3, 0, tm, cm, 32, 2);

    tm = '0; cm = '0;
    for (int i = 0; i <= 3; i++) tm[i] = 1'b1;
    cm[10] = 1'b1;
    run_scn(4, 0, tm, cm, 30, 1);

    tm = '0; cm = '0; tm[0] = 1'b1; tm[4] = 1'b1; cm[4] = 1'b1;
    run_scn(5, 0, tm, cm, 18, 1);

    tm = '0; cm = '0; tm[0] = 1'b1; cm[0] = 1'b1; cm[2] = 1'b1;
    run_scn(6, 0, tm, cm, 6, 0);

    tm = '0; cm = '0;
    for (int i = 0; i <= 3; i++) tm[i] = 1'b1;
    tm[14] = 1'b1;
    run_scn(7, 0, tm, cm, 18, 2);

    tm = '0; cm = '0; tm[0] = 1'b1; tm[1] = 1'b1; cm[14] = 1'b1;
    run_scn(8, 0, tm, cm, 20, 1);

    tm = '0; cm = '0; tm[0] = 1'b1; tm[1] = 1'b1;
    run_scn(9, 1, tm, cm, 8, 2);

    // ---- asynchronous reset mid-pulse with two events queued ----
    trig = 1'b0; clear = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    trig = 1'b1;                 // cycle 0
    @(negedge clk);              // cycle 1
    @(negedge clk);              // cycle 2
    @(negedge clk); trig = 1'b0; // cycle 3
    @(negedge clk);              // cycle 4
    chk("rst pre out", int'(out_a), 0);
    chk("rst pre pending", int'(pend_a), 2);
    chk("rst pre busy_b", int'(busy_b), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst async out", int'(out_a), 1);
    chk("rst async busy", int'(busy_a), 0);
    chk("rst async pending", int'(pend_a), 0);
    chk("rst async busy_b", int'(busy_b), 0);
    chk("rst async out_b", int'(out_b), 0);
    @(negedge clk); rst = 1'b0;
    trig = 1'b1;
    @(negedge clk); trig = 1'b0;
    act_cycles = 0;
    starts     = 0;
    prev       = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (out_a == 1'b0) act_cycles++;
      if (out_a == 1'b0 && !prev) starts++;
      prev = (out_a == 1'b0);
      @(negedge clk);
    end
    chk("post-rst active cycles", act_cycles, 7);
    chk("post-rst pulse count", starts, 1);
    chk("post-rst pending", int'(pend_a), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/key_pulse_gen.md
Name: key_pulse_gen

Overview:
Output-side counterpart of the button debouncer. The debouncer turns long, noisy physical levels into single-cycle event pulses; this block turns single-cycle internal events into clean, fixed-width physical pulses (LED blink, buzzer tick, active-low strobe). Every pulse is followed by a guaranteed idle gap, so a slow observer sees each event separately. Events that arrive during a pulse are queued in a saturating counter. Sits between game/control logic and DE2_115 board outputs.

Parameters:
ON_CYCLES, 7, width of the active pulse in clocks (>=1)
OFF_CYCLES, 7, width of the mandatory idle gap after each pulse in clocks (>=1)
PEND_MAX, 3, maximum number of queued events (>=1)
IDLE_LEVEL, 1, output level when not pulsing (1 = active-low output, matches KEY polarity)

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous reset, active-high
i_trig  in  1  event request; every cycle sampled high counts as one event
i_clear  in  1  synchronous flush of queued events
o_out  out  1  shaped output; ~IDLE_LEVEL while pulsing
o_busy  out  1  high whenever the state is not IDLE
o_pending  out  $clog2(PEND_MAX+1)  current queued-event count
o_done  out  1  one-cycle pulse when the block returns to IDLE
o_drop  out  1  one-cycle pulse when an event is lost because the queue is full

Behaviour:
- All outputs are registered. The down-counter is $clog2(max(ON_CYCLES,OFF_CYCLES)+1) bits wide.
- Reset (async, i_rst=1): state IDLE, o_out=IDLE_LEVEL, o_pending=0, o_busy=0, o_done=0, o_drop=0, counter=0. Reset mid-pulse aborts immediately; queued events are lost.
- IDLE:
  - i_trig=1 → ON on the next edge. o_out goes active in the cycle after i_trig is sampled (latency 1). Counter loads ON_CYCLES-1.
  - o_pending is always 0 in IDLE.
- ON: o_out=~IDLE_LEVEL for exactly ON_CYCLES cycles. When the counter reaches 0 → GAP, and the counter loads OFF_CYCLES-1.
- GAP: o_out=IDLE_LEVEL for exactly OFF_CYCLES cycles. When the counter reaches 0:
  - if o_pending>0 or i_trig=1 → ON, consuming one event;
  - else → IDLE, and o_done=1 in the first IDLE cycle.
- Queue (ON/GAP states):
  - i_trig=1 → o_pending+1 next cycle.
  - At PEND_MAX, the count is held and o_drop=1 next cycle.
- Simultaneous trig and consume (last GAP cycle):
  - pending 0: the trig is consumed directly; pending stays 0.
  - pending n>0: pending stays n; a trig plus a consume never causes a drop, even at PEND_MAX.
- i_clear=1: o_pending←0 next cycle. The same-cycle i_trig is discarded with no o_drop. The pulse or gap already in progress completes normally. A clear on the last GAP cycle means → IDLE.
- i_clear in IDLE alone: no effect. i_clear and i_trig together in IDLE: clear wins, stays IDLE.
- o_busy is asserted from the first ON cycle through the last GAP cycle.
- Back-to-back events: pulse period is exactly ON_CYCLES+OFF_CYCLES, with no extra idle cycle between a GAP and the next ON.

Test Plan:
- Defaults, reset, single i_trig at cycle 0 → o_out=0 cycles 1–7, 1 cycles 8–14, o_busy=1 cycles 1–14, o_done=1 at cycle 15 only, o_pending=0 throughout.
- i_trig at cycles 0, 3, 5 → o_pending 1 at cycle 4, 2 at cycle 6. Pulses active cycles 1–7, 15–21, 29–35. o_pending 1 at cycle 15, 0 at cycle 29. o_done at cycle 43.
- i_trig held high cycles 0–5 (PEND_MAX=3) → o_pending saturates at 3 by cycle 4. o_drop pulses at cycles 5 and 6. Exactly 4 pulses are emitted in total.
- i_trig at cycle 14 only after a cycle-0 trig (last GAP cycle) → second pulse active cycles 15–21, o_pending stays 0, no o_done at cycle 15.
- Three queued events, i_clear at cycle 10 → o_pending=0 at cycle 11. Gap ends cycle 14, o_done at cycle 15, no further pulses. Second run with i_trig and i_clear together at cycle 4 → o_pending unchanged, o_drop=0.
- Reset asserted at cycle 4 of a pulse with o_pending=2 → o_out=1, o_busy=0, o_pending=0 immediately (async). After release, i_trig produces a normal 7-cycle pulse. Repeat with IDLE_LEVEL=0, ON=1, OFF=1 → o_out high 1 cycle, period 2.
